// File: rtl/multiplier_control_taint_track_nbit.sv
// Control FSM for a shift-add sequential multiplier with signed mode, abort
// and a sticky taint bit fed only by the multiplier bits actually examined.
module multiplier_control_taint_track_nbit #(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             start_t,
   input  logic             signed_en,
   input  logic             signed_en_t,
   input  logic             abort,
   input  logic             abort_t,
   input  logic [WIDTH-1:0] multiplierReg,
   input  logic [WIDTH-1:0] multiplierReg_t,
   output logic             busy,
   output logic             productDone,
   output logic             mdld,
   output logic             mrld,
   output logic             rsclear,
   output logic             rsload,
   output logic             rssub,
   output logic             rsshr,
   output logic [IDX_W-1:0] bit_idx,
   output logic             busy_t,
   output logic             productDone_t,
   output logic             mdld_t,
   output logic             mrld_t,
   output logic             rsclear_t,
   output logic             rsload_t,
   output logic             rssub_t,
   output logic             rsshr_t,
   output logic             bit_idx_t
);

   typedef enum logic [2:0] {IDLE, INIT, ADD, SHIFT, DONE} state_t;

   localparam logic [IDX_W-1:0] K_LAST = IDX_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] k, k_nxt, k_inc;
   logic             sgn, sgn_nxt;
   logic             st, st_nxt;

   assign k_inc = k + IDX_W'(1);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         k     <= '0;
         sgn   <= 1'b0;
         st    <= 1'b0;
      end else begin
         state <= state_nxt;
         k     <= k_nxt;
         sgn   <= sgn_nxt;
         st    <= st_nxt;
      end
   end

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      sgn_nxt   = sgn;
      st_nxt    = st | abort_t;   // abort taint counts in every busy cycle
      unique case (state)
         IDLE: begin
            st_nxt = st | start_t;
            if (start) begin
               state_nxt = INIT;
               sgn_nxt   = signed_en;
               st_nxt    = st | start_t | signed_en_t;
            end
         end
         INIT: begin
            k_nxt = '0;
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               st_nxt    = st_nxt | multiplierReg_t[0];
               state_nxt = multiplierReg[0] ? ADD : SHIFT;
            end
         end
         ADD: begin
            if (abort) begin
               state_nxt = IDLE;
               k_nxt     = '0;
            end else begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_nxt = IDLE;
               k_nxt     = '0;
            end else if (k == K_LAST) begin
               state_nxt = DONE;
            end else begin
               k_nxt     = k_inc;
               st_nxt    = st_nxt | multiplierReg_t[k_inc];
               state_nxt = multiplierReg[k_inc] ? ADD : SHIFT;
            end
         end
         DONE: begin
            state_nxt = IDLE;
            k_nxt     = '0;
         end
         default: begin
            state_nxt = IDLE;
            k_nxt     = '0;
         end
      endcase
   end

   always_comb begin
      busy        = (state != IDLE);
      productDone = 1'b0;
      mdld        = 1'b0;
      mrld        = 1'b0;
      rsclear     = 1'b0;
      rsload      = 1'b0;
      rssub       = 1'b0;
      rsshr       = 1'b0;
      unique case (state)
         IDLE: ;
         INIT: begin
            mdld    = 1'b1;
            mrld    = 1'b1;
            rsclear = 1'b1;
         end
         ADD: begin
            // Two's-complement multiplier: the sign bit carries negative weight.
            if (sgn && (k == K_LAST)) rssub = 1'b1;
            else                      rsload = 1'b1;
         end
         SHIFT: rsshr = 1'b1;
         DONE: begin
            rsshr       = 1'b1;
            productDone = 1'b1;
         end
         default: ;
      endcase
   end

   assign bit_idx       = k;
   assign busy_t        = st;
   assign productDone_t = st;
   assign mdld_t        = st;
   assign mrld_t        = st;
   assign rsclear_t     = st;
   assign rsload_t      = st;
   assign rssub_t       = st;
   assign rsshr_t       = st;
   assign bit_idx_t     = st;

endmodule

// File: tb/tb_multiplier_control_taint_track_nbit.sv
// Self-checking bench: table vectors, randomized operations against an
// output-schedule model, and hand sequences for reset, abort and start/abort.
module tb_multiplier_control_taint_track_nbit;

   localparam int W  = 4;
   localparam int IW = $clog2(W);

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0, start_t = 1'b0;
   logic          signed_en = 1'b0, signed_en_t = 1'b0;
   logic          abort = 1'b0, abort_t = 1'b0;
   logic [W-1:0]  multiplierReg = '0, multiplierReg_t = '0;
   logic          busy, productDone, mdld, mrld, rsclear, rsload, rssub, rsshr;
   logic [IW-1:0] bit_idx;
   logic          busy_t, productDone_t, mdld_t, mrld_t, rsclear_t;
   logic          rsload_t, rssub_t, rsshr_t, bit_idx_t;

   multiplier_control_taint_track_nbit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .start(start), .start_t(start_t),
      .signed_en(signed_en), .signed_en_t(signed_en_t),
      .abort(abort), .abort_t(abort_t),
      .multiplierReg(multiplierReg), .multiplierReg_t(multiplierReg_t),
      .busy(busy), .productDone(productDone), .mdld(mdld), .mrld(mrld),
      .rsclear(rsclear), .rsload(rsload), .rssub(rssub), .rsshr(rsshr),
      .bit_idx(bit_idx),
      .busy_t(busy_t), .productDone_t(productDone_t), .mdld_t(mdld_t),
      .mrld_t(mrld_t), .rsclear_t(rsclear_t), .rsload_t(rsload_t),
      .rssub_t(rssub_t), .rsshr_t(rsshr_t), .bit_idx_t(bit_idx_t)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Strobe vector order: busy, productDone, mdld, mrld, rsclear, rsload, rssub, rsshr
   localparam logic [7:0] S_IDLE  = 8'b0000_0000;
   localparam logic [7:0] S_INIT  = 8'b1011_1000;
   localparam logic [7:0] S_LOAD  = 8'b1000_0100;
   localparam logic [7:0] S_SUB   = 8'b1000_0010;
   localparam logic [7:0] S_SHIFT = 8'b1000_0001;
   localparam logic [7:0] S_DONE  = 8'b1100_0001;

   function automatic logic [7:0] strobes();
      return {busy, productDone, mdld, mrld, rsclear, rsload, rssub, rsshr};
   endfunction

   function automatic logic [8:0] taints();
      return {busy_t, productDone_t, mdld_t, mrld_t, rsclear_t,
              rsload_t, rssub_t, rsshr_t, bit_idx_t};
   endfunction

   // Reference model: per-cycle expected output schedule of one multiply,
   // with the multiplier bit whose taint is consumed when leaving that cycle.
   typedef struct {
      logic [7:0]    str;
      logic [IW-1:0] k;
      int            exam;
   } step_t;

   step_t sched[$];
   logic  model_st;

   function automatic void build(input logic [W-1:0] mr, input logic sgn);
      step_t s;
      sched.delete();
      s.str = S_INIT; s.k = '0; s.exam = 0;
      sched.push_back(s);
      for (int j = 0; j < W; j++) begin
         if (mr[j]) begin
            s.str  = (sgn && j == W - 1) ? S_SUB : S_LOAD;
            s.k    = IW'(j);
            s.exam = -1;
            sched.push_back(s);
         end
         s.str  = S_SHIFT;
         s.k    = IW'(j);
         s.exam = (j < W - 1) ? j + 1 : -1;
         sched.push_back(s);
      end
      s.str = S_DONE; s.k = IW'(W - 1); s.exam = -1;
      sched.push_back(s);
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      start = 1'b0; start_t = 1'b0; abort = 1'b0; abort_t = 1'b0;
      signed_en = 1'b0; signed_en_t = 1'b0;
      #2;
      model_st = 1'b0;
      check("reset_strobes", strobes(), S_IDLE);
      check("reset_idx", bit_idx, 0);
      check("reset_taints", taints(), 9'h000);
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   // One complete multiply, compared cycle by cycle; returns the cycle count
   // (accepting edge to productDone inclusive), 0 if productDone never seen.
   task automatic run_op(input logic [W-1:0] mr, input logic [W-1:0] mr_t,
                         input logic sgn, input logic sgn_t, input logic s_t,
                         input logic ab_t, input logic noise, output int lat);
      build(mr, sgn);
      multiplierReg = mr; multiplierReg_t = mr_t;
      signed_en = sgn; signed_en_t = sgn_t;
      start = 1'b1; start_t = s_t;
      abort = 1'b0; abort_t = ab_t;
      model_st = model_st | s_t | sgn_t;
      lat = 0;
      for (int c = 0; c < sched.size(); c++) begin
         @(posedge clk); #1;
         check($sformatf("op_strobes_c%0d", c + 1), strobes(), sched[c].str);
         check($sformatf("op_idx_c%0d", c + 1), bit_idx, sched[c].k);
         check($sformatf("op_taints_c%0d", c + 1), taints(), {9{model_st}});
         if (productDone && lat == 0) lat = c + 1;
         model_st = model_st | ab_t | ((sched[c].exam >= 0) ? mr_t[sched[c].exam] : 1'b0);
         // Starts, start taints and mode changes while busy must all be ignored.
         start       = noise && (c < sched.size() - 1) ? 1'($urandom) : 1'b0;
         start_t     = noise && (c < sched.size() - 1) ? 1'($urandom) : 1'b0;
         signed_en   = noise ? 1'($urandom) : sgn;
         signed_en_t = noise ? 1'($urandom) : 1'b0;
      end
      @(posedge clk); #1;
      check("post_idle_strobes", strobes(), S_IDLE);
      check("post_idle_idx", bit_idx, 0);
      check("post_idle_taints", taints(), {9{model_st}});
      abort_t = 1'b0;
   endtask

   typedef struct {
      logic [W-1:0] mr;
      logic [W-1:0] mr_t;
      logic         sgn;
      logic         sgn_t;
      logic         s_t;
      logic         ab_t;
      int           lat;
      logic         fin_t;
   } vec_t;

   vec_t vecs[8];
   int   lat;

   initial begin
      vecs[0] = '{4'b1011, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0,  9, 1'b0};
      vecs[1] = '{4'b1001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0,  8, 1'b0};
      vecs[2] = '{4'b0101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0,  8, 1'b0};
      vecs[3] = '{4'b0101, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0,  8, 1'b1};
      vecs[4] = '{4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0,  8, 1'b1};
      vecs[5] = '{4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0,  6, 1'b1};
      vecs[6] = '{4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 10, 1'b0};
      vecs[7] = '{4'b0110, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1,  8, 1'b1};

      model_st = 1'b0;
      #1;
      do_reset();

      for (int v = 0; v < 8; v++) begin
         do_reset();
         run_op(vecs[v].mr, vecs[v].mr_t, vecs[v].sgn, vecs[v].sgn_t,
                vecs[v].s_t, vecs[v].ab_t, 1'b0, lat);
         check($sformatf("vec%0d_latency", v), lat, vecs[v].lat);
         check($sformatf("vec%0d_final_taint", v), rsshr_t, vecs[v].fin_t);
      end

      // Asynchronous reset in the middle of SHIFT (k=0) of a tainted multiply.
      do_reset();
      multiplierReg = 4'b1011; multiplierReg_t = 4'b0000;
      start = 1'b1; start_t = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start_t = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("pre_reset_shift", strobes(), S_SHIFT);
      check("pre_reset_taint", taints(), 9'h1FF);
      #2 rst = 1'b0;
      #1;
      check("async_reset_strobes", strobes(), S_IDLE);
      check("async_reset_idx", bit_idx, 0);
      check("async_reset_taints", taints(), 9'h000);
      rst = 1'b1;
      model_st = 1'b0;
      @(posedge clk); #1;

      // Abort in ADD with k=1; start in the same cycle ignored, next cycle accepted.
      multiplierReg = 4'b1011;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_in_add_k1", {strobes(), 4'(bit_idx)}, {S_LOAD, 4'd1});
      abort = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      check("abort_to_idle", strobes(), S_IDLE);
      check("abort_idx", bit_idx, 0);
      abort = 1'b0;
      @(posedge clk); #1;
      check("restart_after_abort", strobes(), S_INIT);
      start = 1'b0;

      // Start and abort together in IDLE; abort taint only counts once busy.
      do_reset();
      multiplierReg = 4'b0101;
      start = 1'b1; abort = 1'b1; abort_t = 1'b1; start_t = 1'b0;
      #1;
      check("idle_abort_taint", taints(), 9'h000);
      @(posedge clk); #1;
      check("start_beats_abort", strobes(), S_INIT);
      check("init_taint_still_clear", taints(), 9'h000);
      start = 1'b0; abort = 1'b0;
      @(posedge clk); #1;
      check("abort_taint_after_init", taints(), 9'h1FF);

      // Randomized multiplies with busy-time noise, checked against the model.
      for (int n = 0; n < 30; n++) begin
         logic [W-1:0] r_mr, r_mt;
         if (n % 5 == 0) do_reset();
         r_mr = W'($urandom);
         r_mt = ($urandom_range(0, 3) == 0) ? W'(1 << $urandom_range(0, W - 1)) : '0;
         run_op(r_mr, r_mt, 1'($urandom), $urandom_range(0, 9) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, 1'b1, lat);
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            start_t = ($urandom_range(0, 7) == 0);
            @(posedge clk);
            model_st = model_st | start_t;
            #1;
            start_t = 1'b0;
            check("gap_taints", taints(), {9{model_st}});
            check("gap_strobes", strobes(), S_IDLE);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
